rx_payload_deframer_bluetooth: RTL and testbench
================================================

Name: rx_payload_deframer_bluetooth

Overview:
RX payload deframer sitting directly upstream of the serial CRC-16 checker in the BLE PHY receive path. It takes the dewhitened serial bit stream after the header, counts out the payload length, and drives the checker's data/valid/clear inputs. It packs payload bits into bytes for the link layer, then captures the 16 received CRC bits and compares them against the checker's remainder to flag crc_ok or crc_err.

Parameters:
LEN_W, 8, payload length field width in bytes (BLE max 255).
CRC_LEN, 16, CRC bit count; also the width of crc_reg_in.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: header decoded, payload follows
payload_len  input  LEN_W  payload length in bytes, sampled on start
abort  input  1  synchronous abort (sync lost)
bit_in  input  1  serial received bit
bit_valid  input  1  bit_in qualifier, one bit per high cycle
crc_reg_in  input  CRC_LEN  remainder from the CRC checker
crc_data_out  output  1  bit to the CRC checker
crc_valid_out  output  1  valid to the CRC checker
crc_clear_out  output  1  reseed request to the CRC checker
byte_out  output  8  assembled payload byte
byte_valid  output  1  one-cycle strobe for byte_out
busy  output  1  high when not IDLE/DONE
done  output  1  one-cycle pulse at end of frame
crc_ok  output  1  CRC matched; held until next start/abort
crc_err  output  1  CRC mismatched; held until next start/abort

Behaviour:
- Reset: state IDLE; all outputs 0; counters, byte shift register, mismatch flag cleared.
- States: IDLE, CLR, PAYLOAD, CRC, DONE.
- IDLE/DONE + start: latch payload_len, clear crc_ok/crc_err, go to CLR.
- In the start cycle, crc_clear_out = 1 combinationally. It is also 1 for the whole CLR cycle, so a two-cycle clear guarantees the checker reseeds even if it was still in its generate state.
- CLR: lasts one cycle. Any bit_valid in this cycle is dropped. Upstream guarantees at least a 2-cycle gap between start and the first bit. Next state is PAYLOAD, or CRC if payload_len == 0.
- PAYLOAD:
  - crc_data_out = bit_in and crc_valid_out = bit_valid, both combinational, so the checker updates on the same edge.
  - Bits are shifted LSB-first: the first bit received lands in byte_out[0].
  - After every 8th bit, byte_out and byte_valid are registered and present the cycle after the 8th bit_valid.
  - The bit counter is LEN_W+3 bits wide. When it reaches payload_len*8, go to CRC.
- CRC:
  - crc_valid_out = 0, so crc_reg_in is frozen.
  - Received CRC bit k (k = 0 is first) is compared with crc_reg_in[CRC_LEN-1-k]; any mismatch sets a sticky flag.
  - On the 16th bit, go to DONE. In that cycle, register done = 1 for one cycle, and set crc_ok = !mismatch and crc_err = mismatch.
- DONE: behaves as IDLE; crc_ok/crc_err are held. bit_valid is ignored in IDLE and DONE.
- start while busy: abandon the current frame without a done pulse and restart via CLR, with the same clear behaviour.
- abort: highest priority after reset.
  - Go to IDLE; done is not pulsed.
  - crc_ok and crc_err are cleared.
  - A partial byte is discarded and byte_valid is not asserted.
- Simultaneous start and abort: abort wins.
- Simultaneous start and bit_valid: start wins and the bit is dropped.
- busy = 1 in CLR, PAYLOAD and CRC.
- crc_clear_out is never high in a cycle where crc_valid_out is high.

Test Plan:
- Checker seeded with uap 8'h47 (remainder 16'h00E2); start with payload_len = 0; send CRC bits 0000_0000_1110_0010 (first to last) -> crc_valid_out never high, done pulse once, crc_ok = 1, crc_err = 0, no byte_valid.
- payload_len = 2; send bytes 8'hA5 then 8'h3C LSB-first; then send the 16 bits of the frozen crc_reg_in MSB-first -> exactly 16 crc_valid_out cycles, byte_valid twice with byte_out 8'hA5 then 8'h3C, crc_ok = 1.
- Same frame with CRC bit 5 inverted -> crc_err = 1, crc_ok = 0, done pulses once.
- Abort asserted after 11 payload bits -> IDLE next cycle, busy = 0, exactly one byte_valid seen, no done, crc_ok = crc_err = 0.
- start asserted during the CRC phase of a frame -> no done for the old frame, crc_clear_out high for 2 cycles, new frame completes correctly.
- bit_valid high in the start cycle and in the CLR cycle -> both bits dropped, crc_valid_out low, byte assembly starts at the next bit.

Source files
------------

// File: rtl/rx_payload_deframer_bluetooth.sv
// rx_payload_deframer_bluetooth
// Sits between the BLE dewhitener and the serial CRC-16 checker. After a
// header is decoded it counts out payload_len bytes of serial bits, feeds them
// to the checker, packs them LSB-first into bytes for the link layer, then
// compares the 16 received CRC bits with the checker's frozen remainder.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             header decoded, payload follows (one-cycle pulse)
//   payload_len       payload length in bytes, sampled on start
//   abort             synchronous abort, highest priority
//   bit_in, bit_valid serial bit stream and its qualifier
//   crc_reg_in        remainder from the CRC checker
//   crc_data_out, crc_valid_out, crc_clear_out   CRC checker drive
//   byte_out, byte_valid                         assembled payload bytes
//   busy, done, crc_ok, crc_err                  frame status
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | one-cycle checker reseed, incoming bits dropped
// PAYLOAD | payload bits fed to checker and packed into bytes
// CRC     | received CRC bits compared against frozen remainder
// DONE    | frame finished, result held; behaves as IDLE

module rx_payload_deframer_bluetooth #(
    parameter int LEN_W   = 8,
    parameter int CRC_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   payload_len,
    input  logic               abort,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic [CRC_LEN-1:0] crc_reg_in,
    output logic               crc_data_out,
    output logic               crc_valid_out,
    output logic               crc_clear_out,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    output logic               busy,
    output logic               done,
    output logic               crc_ok,
    output logic               crc_err
);

    localparam int CNT_W = $clog2(CRC_LEN);
    localparam int BIT_W = LEN_W + 3;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLR     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] CRC     = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]       state;
    logic [LEN_W-1:0] len_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic [CNT_W-1:0] crc_cnt;
    logic [CNT_W-1:0] crc_idx;
    logic             mismatch;
    logic             mismatch_next;
    logic             start_eff;

    // abort outranks start; a start also steals any bit arriving with it
    assign start_eff     = start & ~abort;

    assign crc_data_out  = (state == PAYLOAD) & bit_in;
    assign crc_valid_out = (state == PAYLOAD) & bit_valid & ~start & ~abort;
    // clear spans the start cycle and CLR so a checker still generating reseeds
    assign crc_clear_out = start_eff | (state == CLR);
    assign busy          = (state == CLR) | (state == PAYLOAD) | (state == CRC);

    // new bit enters at the MSB; after 8 shifts the first bit sits in bit 0
    assign shreg_next    = {bit_in, shreg[7:1]};
    assign bit_cnt_next  = bit_cnt + BIT_W'(1);

    // received CRC bits arrive MSB-first relative to the remainder
    assign crc_idx       = CNT_W'(CRC_LEN - 1) - crc_cnt;
    assign mismatch_next = mismatch | (bit_in ^ crc_reg_in[crc_idx]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_reg    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            crc_cnt    <= '0;
            mismatch   <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
                bit_cnt  <= '0;
                shreg    <= '0;
                crc_cnt  <= '0;
                mismatch <= 1'b0;
            end else if (start) begin
                state    <= CLR;
                len_reg  <= payload_len;
                crc_ok   <= 1'b0;
                crc_err  <= 1'b0;
                bit_cnt  <= '0;
                shreg    <= '0;
                crc_cnt  <= '0;
                mismatch <= 1'b0;
            end else begin
                case (state)
                    CLR: begin
                        state <= (len_reg == '0) ? CRC : PAYLOAD;
                    end
                    PAYLOAD: begin
                        if (bit_valid) begin
                            shreg   <= shreg_next;
                            bit_cnt <= bit_cnt_next;
                            if (bit_cnt[2:0] == 3'd7) begin
                                byte_out   <= shreg_next;
                                byte_valid <= 1'b1;
                            end
                            if (bit_cnt_next == {len_reg, 3'b000}) begin
                                state <= CRC;
                            end
                        end
                    end
                    CRC: begin
                        if (bit_valid) begin
                            mismatch <= mismatch_next;
                            crc_cnt  <= crc_cnt + CNT_W'(1);
                            if (crc_cnt == CNT_W'(CRC_LEN - 1)) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                crc_ok  <= ~mismatch_next;
                                crc_err <= mismatch_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_payload_deframer_bluetooth.sv
// Directed bench for rx_payload_deframer_bluetooth. Inputs change on the
// falling edge; a posedge monitor tallies strobes seen by downstream logic.
module tb_rx_payload_deframer_bluetooth;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  payload_len;
    logic        abort;
    logic        bit_in;
    logic        bit_valid;
    logic [15:0] crc_reg_in;
    logic        crc_data_out;
    logic        crc_valid_out;
    logic        crc_clear_out;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        crc_err;

    int checks   = 0;
    int failures = 0;

    int n_valid   = 0;
    int n_byte    = 0;
    int n_done    = 0;
    int n_clr     = 0;
    int n_overlap = 0;
    logic [7:0] byte_log[$];

    always #5 clk = ~clk;

    rx_payload_deframer_bluetooth dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .payload_len   (payload_len),
        .abort         (abort),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .crc_reg_in    (crc_reg_in),
        .crc_data_out  (crc_data_out),
        .crc_valid_out (crc_valid_out),
        .crc_clear_out (crc_clear_out),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .busy          (busy),
        .done          (done),
        .crc_ok        (crc_ok),
        .crc_err       (crc_err)
    );

    always @(posedge clk) begin
        if (crc_valid_out) n_valid++;
        if (byte_valid) begin
            n_byte++;
            byte_log.push_back(byte_out);
        end
        if (done) n_done++;
        if (crc_clear_out) n_clr++;
        if (crc_clear_out && crc_valid_out) n_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called on a falling edge; returns on the next falling edge
    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_crc(input logic [15:0] c);
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
    endtask

    // start cycle plus CLR cycle; returns in the first PAYLOAD/CRC cycle
    task automatic start_frame(input logic [7:0] len);
        start       = 1'b1;
        payload_len = len;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    int s_valid, s_byte, s_done, s_clr, s_log;

    task automatic snap();
        s_valid = n_valid;
        s_byte  = n_byte;
        s_done  = n_done;
        s_clr   = n_clr;
        s_log   = byte_log.size();
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        payload_len = 8'd0;
        abort       = 1'b0;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        crc_reg_in  = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ok_err", {30'd0, crc_ok, crc_err}, 32'd0);
        chk("rst_byte", {23'd0, byte_valid, byte_out}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // empty payload, remainder 00E2
        crc_reg_in = 16'h00E2;
        snap();
        start = 1'b1;
        payload_len = 8'd0;
        #1;
        chk("t1_clear_start", 32'(crc_clear_out), 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t1_clear_clr", 32'(crc_clear_out), 32'd1);
        chk("t1_busy_clr", 32'(busy), 32'd1);
        @(negedge clk);
        send_crc(16'b0000_0000_1110_0010);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_ok", {30'd0, crc_ok, crc_err}, 32'd2);
        @(negedge clk);
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_valid_cnt", 32'(n_valid - s_valid), 32'd0);
        chk("t1_byte_cnt", 32'(n_byte - s_byte), 32'd0);
        chk("t1_done_cnt", 32'(n_done - s_done), 32'd1);
        chk("t1_clr_cnt", 32'(n_clr - s_clr), 32'd2);

        // two-byte payload, good CRC
        crc_reg_in = 16'hBEEF;
        snap();
        start_frame(8'd2);
        send_byte(8'hA5);
        chk("t2_bv0", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'hA5});
        send_byte(8'h3C);
        chk("t2_bv1", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'h3C});
        send_crc(16'hBEEF);
        chk("t2_ok", {29'd0, done, crc_ok, crc_err}, 32'b110);
        @(negedge clk);
        chk("t2_valid_cnt", 32'(n_valid - s_valid), 32'd16);
        chk("t2_byte_cnt", 32'(n_byte - s_byte), 32'd2);
        chk("t2_log0", 32'(byte_log[s_log]), 32'hA5);
        chk("t2_log1", 32'(byte_log[s_log + 1]), 32'h3C);
        chk("t2_done_cnt", 32'(n_done - s_done), 32'd1);
        chk("t2_ok_held", 32'(crc_ok), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t2_abort_clears_ok", {30'd0, crc_ok, crc_err}, 32'd0);

        // same frame, CRC bit 5 inverted
        snap();
        start_frame(8'd2);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_crc(16'hBEEF ^ 16'h0400);
        chk("t3_err", {29'd0, done, crc_ok, crc_err}, 32'b101);
        @(negedge clk);
        chk("t3_err_held", {30'd0, crc_ok, crc_err}, 32'd1);
        chk("t3_done_cnt", 32'(n_done - s_done), 32'd1);

        // abort after 11 payload bits
        snap();
        start_frame(8'd2);
        chk("t4_start_clears_err", {30'd0, crc_ok, crc_err}, 32'd0);
        send_byte(8'h96);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("t4_byte_cnt", 32'(n_byte - s_byte), 32'd1);
        chk("t4_log0", 32'(byte_log[s_log]), 32'h96);
        chk("t4_done_cnt", 32'(n_done - s_done), 32'd0);
        chk("t4_ok_err", {30'd0, crc_ok, crc_err}, 32'd0);

        // restart during CRC phase
        crc_reg_in = 16'h1234;
        snap();
        start_frame(8'd1);
        send_byte(8'h5A);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t5_busy_crc", 32'(busy), 32'd1);
        s_clr = n_clr;
        start_frame(8'd1);
        chk("t5_clr_cnt", 32'(n_clr - s_clr), 32'd2);
        chk("t5_no_old_done", 32'(n_done - s_done), 32'd0);
        send_byte(8'h81);
        chk("t5_bv", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'h81});
        send_crc(16'h1234);
        chk("t5_ok", {29'd0, done, crc_ok, crc_err}, 32'b110);
        @(negedge clk);
        chk("t5_done_cnt", 32'(n_done - s_done), 32'd1);

        // bit_valid in the start and CLR cycles is dropped
        crc_reg_in = 16'hC3A1;
        snap();
        start = 1'b1;
        payload_len = 8'd1;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t6_valid_clr", 32'(crc_valid_out), 32'd0);
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in = 1'b0;
        chk("t6_valid_cnt_pre", 32'(n_valid - s_valid), 32'd0);
        send_byte(8'h5A);
        chk("t6_bv", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'h5A});
        send_crc(16'hC3A1);
        chk("t6_ok", {29'd0, done, crc_ok, crc_err}, 32'b110);
        @(negedge clk);
        chk("t6_valid_cnt", 32'(n_valid - s_valid), 32'd8);
        chk("t6_byte_cnt", 32'(n_byte - s_byte), 32'd1);

        chk("clear_valid_overlap", 32'(n_overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
